// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU/cmd/op codes, mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWAIT = 4'd8,
    S_ALUWB   = 4'd9,
    S_BRANCH  = 4'd10
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MOD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1100;
  localparam logic [3:0] CMD_MOD = 4'b0000;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational DP cmd decode: ALU operation, flag-write mask, multicycle and implemented flags.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] cmd_i,
  input  logic       s_i,
  output logic [2:0] alu_ctrl_o,
  output logic [1:0] flag_mask_o,
  output logic       multi_o,
  output logic       impl_o
);

  logic arith;

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    multi_o    = 1'b0;
    impl_o     = 1'b1;
    arith      = 1'b0;
    case (cmd_i)
      CMD_ADD: arith = 1'b1;
      CMD_SUB: begin
        alu_ctrl_o = ALU_SUB;
        arith      = 1'b1;
      end
      CMD_AND: alu_ctrl_o = ALU_AND;
      CMD_MUL: begin
        alu_ctrl_o = ALU_MUL;
        multi_o    = 1'b1;
      end
      CMD_MOD: begin
        alu_ctrl_o = ALU_MOD;
        multi_o    = 1'b1;
      end
      default: impl_o = 1'b0;
    endcase
  end

  // C,V only carry meaning for add/subtract results
  assign flag_mask_o = {s_i, s_i & arith};

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the shared-ALU datapath; Moore outputs gated by CondEx/MemReady/Rd.
// Stalls in FETCH/MEMRD/MEMWR until MemReady; MUL/MOD hold the ALU for exactly N cycles.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int MOD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       Illegal
);

  localparam int CW = $clog2(max2(MUL_CYCLES, MOD_CYCLES) + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] MOD_LOAD = CW'(MOD_CYCLES - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;

  logic [2:0]      dec_alu;
  logic [1:0]      dec_flags;
  logic            dec_multi;
  logic            dec_impl;
  logic [CW-1:0]   n_load;
  logic            imm_op;
  logic            load_op;
  logic            rd_pc;

  logic            ir_w;
  logic            pc_w;
  logic            reg_w;
  logic            mem_w;
  logic [1:0]      flag_w;

  alu_op_decoder u_dec (
    .cmd_i       (Funct[4:1]),
    .s_i         (Funct[0]),
    .alu_ctrl_o  (dec_alu),
    .flag_mask_o (dec_flags),
    .multi_o     (dec_multi),
    .impl_o      (dec_impl)
  );

  assign imm_op  = Funct[5];
  assign load_op = Funct[0];
  assign rd_pc   = (Rd == 4'hF);
  assign n_load  = (dec_alu == ALU_MUL) ? MUL_LOAD : MOD_LOAD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH:  if (MemReady) state_q <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_MEM:  state_q <= S_MEMADR;
            OP_DP:   state_q <= !dec_impl ? S_FETCH : (imm_op ? S_EXECI : S_EXECR);
            OP_BR:   state_q <= S_BRANCH;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: state_q <= load_op ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (MemReady) state_q <= S_MEMWB;
        S_MEMWR:  if (MemReady) state_q <= S_FETCH;
        S_EXECR, S_EXECI: begin
          if (dec_multi) begin
            cnt_q   <= n_load;
            state_q <= (n_load == '0) ? S_ALUWB : S_ALUWAIT;
          end else begin
            state_q <= S_ALUWB;
          end
        end
        // EXEC counted the first ALU cycle, so leaving on a count of 1 gives N in total
        S_ALUWAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_ALUWB;
        end
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    flag_w     = 2'b00;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_RD1;
    ALUSrcB    = SRCB_RD2;
    ImmSrc     = IMM_DP;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_w      = MemReady;
        pc_w      = MemReady;
        ResultSrc = RES_ALU;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        Illegal = (Op == OP_ILL) || ((Op == OP_DP) && !dec_impl);
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_MEM;
      end
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWR: begin
        AdrSrc = 1'b1;
        RegSrc = 2'b10;
        mem_w  = CondEx & MemReady;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        reg_w     = CondEx;
        pc_w      = CondEx & rd_pc;
      end
      S_EXECR, S_EXECI, S_ALUWAIT: begin
        ALUSrcB    = imm_op ? SRCB_IMM : SRCB_RD2;
        ALUControl = dec_alu;
      end
      S_ALUWB: begin
        reg_w  = CondEx;
        pc_w   = CondEx & rd_pc;
        flag_w = CondEx ? dec_flags : 2'b00;
      end
      S_BRANCH: begin
        ResultSrc = RES_ALU;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_BR;
        RegSrc    = 2'b01;
        pc_w      = CondEx;
      end
      default: ;
    endcase
  end

  // No strobe may reach the datapath while reset is held, even with MemReady high
  assign IRWrite = reset & ir_w;
  assign PCWrite = reset & pc_w;
  assign RegW    = reset & reg_w;
  assign MemW    = reset & mem_w;
  assign FlagW   = reset ? flag_w : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus reset/MOD_CYCLES=1 sequence.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'h0;
  logic       CondEx = 1'b1;
  logic       MemReady = 1'b1;
  wire [20:0] o0;
  wire [20:0] o1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MUL_CYCLES(4), .MOD_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
    .MemReady(MemReady), .IRWrite(o0[20]), .PCWrite(o0[19]), .AdrSrc(o0[18]),
    .RegW(o0[17]), .MemW(o0[16]), .ResultSrc(o0[15:14]), .ALUSrcA(o0[13:12]),
    .ALUSrcB(o0[11:10]), .ImmSrc(o0[9:8]), .RegSrc(o0[7:6]), .ALUControl(o0[5:3]),
    .FlagW(o0[2:1]), .Illegal(o0[0])
  );

  multicycle_controller #(.MUL_CYCLES(4), .MOD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
    .MemReady(MemReady), .IRWrite(o1[20]), .PCWrite(o1[19]), .AdrSrc(o1[18]),
    .RegW(o1[17]), .MemW(o1[16]), .ResultSrc(o1[15:14]), .ALUSrcA(o1[13:12]),
    .ALUSrcB(o1[11:10]), .ImmSrc(o1[9:8]), .RegSrc(o1[7:6]), .ALUControl(o1[5:3]),
    .FlagW(o1[2:1]), .Illegal(o1[0])
  );

  // {IRWrite,PCWrite,AdrSrc,RegW,MemW,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegSrc,ALUControl,FlagW,Illegal}
  function automatic logic [20:0] pk(input logic ir, input logic pc, input logic adr,
                                     input logic rw, input logic mw, input logic [1:0] res,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [1:0] rs,
                                     input logic [2:0] alu, input logic [1:0] fw,
                                     input logic ill);
    return {ir, pc, adr, rw, mw, res, sa, sb, imm, rs, alu, fw, ill};
  endfunction

  function automatic logic [20:0] e_fetch(input logic mr);
    return pk(mr, mr, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_decode(input logic ill);
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, ill);
  endfunction
  function automatic logic [20:0] e_memadr();
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_memrd();
    return pk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_memwr(input logic mw);
    return pk(0, 0, 1, 0, mw, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_memwb(input logic rw, input logic pw);
    return pk(0, pw, 0, rw, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_exec(input logic [1:0] sb, input logic [2:0] alu);
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b00, sb, 2'b00, 2'b00, alu, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_aluwb(input logic rw, input logic pw, input logic [1:0] fw);
    return pk(0, pw, 0, rw, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, fw, 0);
  endfunction
  function automatic logic [20:0] e_branch(input logic pw);
    return pk(0, pw, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 0);
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        cond;
    logic        mr;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                     input logic cond, input logic mr, input logic [20:0] exp);
    vec_t v;
    v.op = op; v.funct = funct; v.rd = rd; v.cond = cond; v.mr = mr; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic chk(input logic [20:0] act, input logic [20:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                     input logic cond, input logic mr);
    @(negedge clk);
    reset = 1'b1;
    Op = op; Funct = funct; Rd = rd; CondEx = cond; MemReady = mr;
    #1;
  endtask

  initial begin
    // ADD reg, S=1: four cycles, RegW and both flag groups in ALUWB
    add(2'b00, 6'b001001, 4'h3, 1, 1, e_fetch(1));
    add(2'b00, 6'b001001, 4'h3, 1, 1, e_decode(0));
    add(2'b00, 6'b001001, 4'h3, 1, 1, e_exec(2'b00, 3'b000));
    add(2'b00, 6'b001001, 4'h3, 1, 1, e_aluwb(1, 0, 2'b11));
    // SUB imm to PC, S=0
    add(2'b00, 6'b100100, 4'hF, 1, 1, e_fetch(1));
    add(2'b00, 6'b100100, 4'hF, 1, 1, e_decode(0));
    add(2'b00, 6'b100100, 4'hF, 1, 1, e_exec(2'b01, 3'b001));
    add(2'b00, 6'b100100, 4'hF, 1, 1, e_aluwb(1, 1, 2'b00));
    // AND reg, S=1: only N,Z written
    add(2'b00, 6'b010001, 4'h4, 1, 1, e_fetch(1));
    add(2'b00, 6'b010001, 4'h4, 1, 1, e_decode(0));
    add(2'b00, 6'b010001, 4'h4, 1, 1, e_exec(2'b00, 3'b100));
    add(2'b00, 6'b010001, 4'h4, 1, 1, e_aluwb(1, 0, 2'b10));
    // ADD to PC with CondEx=0: no strobes in ALUWB
    add(2'b00, 6'b001001, 4'hF, 0, 1, e_fetch(1));
    add(2'b00, 6'b001001, 4'hF, 0, 1, e_decode(0));
    add(2'b00, 6'b001001, 4'hF, 0, 1, e_exec(2'b00, 3'b000));
    add(2'b00, 6'b001001, 4'hF, 0, 1, e_aluwb(0, 0, 2'b00));
    // MUL reg, 4 ALU cycles: EXECR + 3 ALUWAIT
    add(2'b00, 6'b011000, 4'h2, 1, 1, e_fetch(1));
    add(2'b00, 6'b011000, 4'h2, 1, 1, e_decode(0));
    for (int i = 0; i < 4; i++) add(2'b00, 6'b011000, 4'h2, 1, 1, e_exec(2'b00, 3'b011));
    add(2'b00, 6'b011000, 4'h2, 1, 1, e_aluwb(1, 0, 2'b00));
    // Modulo imm S=1, 8 ALU cycles
    add(2'b00, 6'b100001, 4'h6, 1, 1, e_fetch(1));
    add(2'b00, 6'b100001, 4'h6, 1, 1, e_decode(0));
    for (int i = 0; i < 8; i++) add(2'b00, 6'b100001, 4'h6, 1, 1, e_exec(2'b01, 3'b010));
    add(2'b00, 6'b100001, 4'h6, 1, 1, e_aluwb(1, 0, 2'b10));
    // LDR to PC: fetch stall, then 3 MEMRD stall cycles
    add(2'b01, 6'b011001, 4'hF, 1, 0, e_fetch(0));
    add(2'b01, 6'b011001, 4'hF, 1, 0, e_fetch(0));
    add(2'b01, 6'b011001, 4'hF, 1, 1, e_fetch(1));
    add(2'b01, 6'b011001, 4'hF, 1, 1, e_decode(0));
    add(2'b01, 6'b011001, 4'hF, 1, 1, e_memadr());
    for (int i = 0; i < 3; i++) add(2'b01, 6'b011001, 4'hF, 1, 0, e_memrd());
    add(2'b01, 6'b011001, 4'hF, 1, 1, e_memrd());
    add(2'b01, 6'b011001, 4'hF, 1, 1, e_memwb(1, 1));
    // STR with CondEx=0: waits for MemReady, never writes
    add(2'b01, 6'b000000, 4'h5, 0, 1, e_fetch(1));
    add(2'b01, 6'b000000, 4'h5, 0, 1, e_decode(0));
    add(2'b01, 6'b000000, 4'h5, 0, 1, e_memadr());
    for (int i = 0; i < 2; i++) add(2'b01, 6'b000000, 4'h5, 0, 0, e_memwr(0));
    add(2'b01, 6'b000000, 4'h5, 0, 1, e_memwr(0));
    // STR with CondEx=1: MemW only in the MemReady cycle
    add(2'b01, 6'b000000, 4'h5, 1, 1, e_fetch(1));
    add(2'b01, 6'b000000, 4'h5, 1, 1, e_decode(0));
    add(2'b01, 6'b000000, 4'h5, 1, 1, e_memadr());
    add(2'b01, 6'b000000, 4'h5, 1, 0, e_memwr(0));
    add(2'b01, 6'b000000, 4'h5, 1, 1, e_memwr(1));
    // Illegal op class, then unimplemented DP cmd
    add(2'b11, 6'b001001, 4'h1, 1, 1, e_fetch(1));
    add(2'b11, 6'b001001, 4'h1, 1, 1, e_decode(1));
    add(2'b00, 6'b000010, 4'h1, 1, 1, e_fetch(1));
    add(2'b00, 6'b000010, 4'h1, 1, 1, e_decode(1));
    // Branch taken / not taken
    add(2'b10, 6'b000000, 4'h0, 1, 1, e_fetch(1));
    add(2'b10, 6'b000000, 4'h0, 1, 1, e_decode(0));
    add(2'b10, 6'b000000, 4'h0, 1, 1, e_branch(1));
    add(2'b10, 6'b000000, 4'h0, 0, 1, e_fetch(1));
    add(2'b10, 6'b000000, 4'h0, 0, 1, e_decode(0));
    add(2'b10, 6'b000000, 4'h0, 0, 1, e_branch(0));

    // Reset held with MemReady high: strobes off, FETCH selects
    Op = 2'b00; Funct = 6'b001001; MemReady = 1'b1;
    @(negedge clk);
    #1;
    chk(o0, e_fetch(0), "reset_state");
    chk(o1, e_fetch(0), "reset_state_dut1");

    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].cond, tbl[i].mr);
      chk(o0, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Reset asserted while a MUL sits in ALUWAIT
    drv(2'b00, 6'b011000, 4'h2, 1, 1); chk(o0, e_fetch(1), "mul_fetch");
    drv(2'b00, 6'b011000, 4'h2, 1, 1); chk(o0, e_decode(0), "mul_decode");
    drv(2'b00, 6'b011000, 4'h2, 1, 1); chk(o0, e_exec(2'b00, 3'b011), "mul_exec");
    drv(2'b00, 6'b011000, 4'h2, 1, 1); chk(o0, e_exec(2'b00, 3'b011), "mul_wait");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk(o0, e_fetch(0), "rst_mid_wait");
    @(negedge clk);
    #1;
    chk(o0, e_fetch(0), "rst_hold");

    // Release into a MOD: dut keeps waiting, dut1 (MOD_CYCLES=1) skips ALUWAIT
    drv(2'b00, 6'b100001, 4'h7, 1, 1);
    chk(o0, e_fetch(1), "rel_fetch");
    chk(o1, e_fetch(1), "rel_fetch_dut1");
    drv(2'b00, 6'b100001, 4'h7, 1, 1);
    chk(o0, e_decode(0), "rel_decode_noregw");
    chk(o1, e_decode(0), "mod1_decode");
    drv(2'b00, 6'b100001, 4'h7, 1, 1);
    chk(o0, e_exec(2'b01, 3'b010), "mod8_exec");
    chk(o1, e_exec(2'b01, 3'b010), "mod1_exec");
    drv(2'b00, 6'b100001, 4'h7, 1, 1);
    chk(o0, e_exec(2'b01, 3'b010), "mod8_wait");
    chk(o1, e_aluwb(1, 0, 2'b10), "mod1_aluwb");
    drv(2'b00, 6'b100001, 4'h7, 1, 1);
    chk(o1, e_fetch(1), "mod1_refetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
